trap_ctrl: RTL and testbench



---
 rtl/trap_ctrl_if.sv | 31 +++
 rtl/trap_ctrl.sv | 179 +++++++++++++++++
 tb/tb_trap_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/trap_ctrl_if.sv
// EX-stage / PC-unit facing signals of the machine-mode trap controller.
// The master side drives events and interrupt lines; the slave side is trap_ctrl.
interface trap_ctrl_if;
    logic        ext_irq;
    logic        timer_irq;
    logic        bus_stall;
    logic        ex_wfi;
    logic        ex_mret;
    logic [31:0] ex_pc;
    logic        csr_we;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        is_wfi;
    logic        interrupt;
    logic        interrupt_re;
    logic [31:0] mtvec;
    logic [31:0] mepc;

    modport master (
        output ext_irq, timer_irq, bus_stall, ex_wfi, ex_mret, ex_pc,
               csr_we, csr_addr, csr_wdata,
        input  csr_rdata, is_wfi, interrupt, interrupt_re, mtvec, mepc
    );

    modport slave (
        input  ext_irq, timer_irq, bus_stall, ex_wfi, ex_mret, ex_pc,
               csr_we, csr_addr, csr_wdata,
        output csr_rdata, is_wfi, interrupt, interrupt_re, mtvec, mepc
    );
endinterface

// File: rtl/trap_ctrl.sv
// Machine-mode trap and WFI controller: interrupt CSRs, RUN/SLEEP sequencing,
// and one-cycle trap-entry / MRET pulses that steer the fetch PC.
module trap_ctrl #(
    parameter logic [31:0] MTVEC_RST = 32'h0001_0000
) (
    input logic        clk,
    input logic        rst,
    trap_ctrl_if.slave bus
);
    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MIE     = 12'h304;
    localparam logic [11:0] ADDR_MTVEC   = 12'h305;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MIP     = 12'h344;

    typedef enum logic {
        RUN,
        SLEEP
    } state_e;

    state_e      state_q, state_d;
    logic        int_q, int_d;
    logic        int_re_q, int_re_d;
    logic        mie_q, mie_d;       // mstatus.MIE
    logic        mpie_q, mpie_d;     // mstatus.MPIE
    logic        meie_q, meie_d;
    logic        mtie_q, mtie_d;
    logic [29:0] mtvec_q, mtvec_d;
    logic [29:0] mepc_q, mepc_d;
    logic [29:0] wfi_pc_q, wfi_pc_d;

    logic wake;
    logic take;
    logic accept;

    assign wake   = (meie_q & bus.ext_irq) | (mtie_q & bus.timer_irq);
    assign take   = mie_q & wake;
    assign accept = (state_q == RUN) && !bus.bus_stall;

    // NOTE: state is updated with non-blocking assignments only, and rst is
    // sampled on the clock edge, so reset behaves like any other synchronous input.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= RUN;
            int_q    <= 1'b0;
            int_re_q <= 1'b0;
            mie_q    <= 1'b0;
            mpie_q   <= 1'b0;
            meie_q   <= 1'b0;
            mtie_q   <= 1'b0;
            mtvec_q  <= MTVEC_RST[31:2];
            mepc_q   <= '0;
            wfi_pc_q <= '0;
        end else begin
            state_q  <= state_d;
            int_q    <= int_d;
            int_re_q <= int_re_d;
            mie_q    <= mie_d;
            mpie_q   <= mpie_d;
            meie_q   <= meie_d;
            mtie_q   <= mtie_d;
            mtvec_q  <= mtvec_d;
            mepc_q   <= mepc_d;
            wfi_pc_q <= wfi_pc_d;
        end
    end

    // A WFI only sleeps when nothing is already waking it; otherwise it is a NOP.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN: begin
                if (accept && !take && !bus.ex_mret && bus.ex_wfi && !wake) begin
                    state_d = SLEEP;
                end
            end
            SLEEP: begin
                if (wake) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        int_d    = 1'b0;
        int_re_d = 1'b0;
        mie_d    = mie_q;
        mpie_d   = mpie_q;
        meie_d   = meie_q;
        mtie_d   = mtie_q;
        mtvec_d  = mtvec_q;
        mepc_d   = mepc_q;
        wfi_pc_d = wfi_pc_q;

        unique case (state_q)
            RUN: begin
                if (accept) begin
                    if (take) begin
                        // The EX instruction is squashed and re-executed after MRET.
                        int_d  = 1'b1;
                        mepc_d = bus.ex_pc[31:2];
                        mpie_d = mie_q;
                        mie_d  = 1'b0;
                    end else begin
                        if (bus.csr_we) begin
                            case (bus.csr_addr)
                                ADDR_MSTATUS: begin
                                    mie_d  = bus.csr_wdata[3];
                                    mpie_d = bus.csr_wdata[7];
                                end
                                ADDR_MIE: begin
                                    meie_d = bus.csr_wdata[11];
                                    mtie_d = bus.csr_wdata[7];
                                end
                                ADDR_MTVEC: mtvec_d = bus.csr_wdata[31:2];
                                ADDR_MEPC:  mepc_d  = bus.csr_wdata[31:2];
                                default: ;
                            endcase
                        end
                        if (bus.ex_mret) begin
                            int_re_d = 1'b1;
                            mie_d    = mpie_q;
                            mpie_d   = 1'b1;
                        end else if (bus.ex_wfi && !wake) begin
                            wfi_pc_d = bus.ex_pc[31:2];
                        end
                    end
                end
            end
            SLEEP: begin
                if (wake && mie_q) begin
                    // Return lands on the instruction after the WFI; wraps at 2^32.
                    int_d  = 1'b1;
                    mepc_d = wfi_pc_q + 30'd1;
                    mpie_d = 1'b1;
                    mie_d  = 1'b0;
                end
            end
            default: ;
        endcase
    end

    logic [31:0] rdata;

    always_comb begin
        rdata = '0;
        case (bus.csr_addr)
            ADDR_MSTATUS: begin
                rdata[12:11] = 2'b11;
                rdata[7]     = mpie_q;
                rdata[3]     = mie_q;
            end
            ADDR_MIE: begin
                rdata[11] = meie_q;
                rdata[7]  = mtie_q;
            end
            ADDR_MTVEC: rdata = {mtvec_q, 2'b00};
            ADDR_MEPC:  rdata = {mepc_q, 2'b00};
            ADDR_MIP: begin
                rdata[11] = bus.ext_irq;
                rdata[7]  = bus.timer_irq;
            end
            default: ;
        endcase
    end

    assign bus.csr_rdata    = rdata;
    assign bus.is_wfi       = (state_q == SLEEP);
    assign bus.interrupt    = int_q;
    assign bus.interrupt_re = int_re_q;
    assign bus.mtvec        = {mtvec_q, 2'b00};
    assign bus.mepc         = {mepc_q, 2'b00};

    logic unused_pc_bits;
    assign unused_pc_bits = ^{bus.ex_pc[1:0], bus.csr_wdata[1:0]};
endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: a rule-level model checked every cycle,
// plus literal expectations taken straight from the trap/WFI scenarios.
module tb_trap_ctrl;
    logic clk = 1'b0;
    logic rst;

    trap_ctrl_if bus ();

    trap_ctrl #(.MTVEC_RST(32'h0001_0000)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Architectural model: trap state as the programmer sees it.
    bit          model_valid = 1'b0;
    logic        m_sleep, m_mie, m_mpie, m_meie, m_mtie, m_int, m_int_re;
    logic [31:0] m_mtvec, m_mepc, m_wfi_pc;

    function automatic logic [31:0] model_read(input logic [11:0] addr);
        logic [31:0] v;
        v = 32'h0;
        case (addr)
            12'h300: v = 32'h1800 | (m_mpie ? 32'h80 : 32'h0) | (m_mie ? 32'h8 : 32'h0);
            12'h304: v = (m_meie ? 32'h800 : 32'h0) | (m_mtie ? 32'h80 : 32'h0);
            12'h305: v = m_mtvec;
            12'h341: v = m_mepc;
            12'h344: v = (bus.ext_irq ? 32'h800 : 32'h0) | (bus.timer_irq ? 32'h80 : 32'h0);
            default: v = 32'h0;
        endcase
        return v;
    endfunction

    always @(posedge clk) begin : model
        logic wake;
        logic o_mpie;
        m_int    = 1'b0;
        m_int_re = 1'b0;
        if (rst) begin
            m_sleep     = 1'b0;
            m_mie       = 1'b0;
            m_mpie      = 1'b0;
            m_meie      = 1'b0;
            m_mtie      = 1'b0;
            m_mtvec     = 32'h0001_0000;
            m_mepc      = 32'h0;
            m_wfi_pc    = 32'h0;
            model_valid = 1'b1;
        end else begin
            wake = (m_meie && bus.ext_irq) || (m_mtie && bus.timer_irq);
            if (!m_sleep) begin
                if (!bus.bus_stall) begin
                    if (m_mie && wake) begin
                        m_int  = 1'b1;
                        m_mepc = bus.ex_pc & 32'hFFFF_FFFC;
                        m_mpie = m_mie;
                        m_mie  = 1'b0;
                    end else begin
                        o_mpie = m_mpie;
                        if (bus.csr_we) begin
                            case (bus.csr_addr)
                                12'h300: begin
                                    m_mie  = bus.csr_wdata[3];
                                    m_mpie = bus.csr_wdata[7];
                                end
                                12'h304: begin
                                    m_meie = bus.csr_wdata[11];
                                    m_mtie = bus.csr_wdata[7];
                                end
                                12'h305: m_mtvec = bus.csr_wdata & 32'hFFFF_FFFC;
                                12'h341: m_mepc  = bus.csr_wdata & 32'hFFFF_FFFC;
                                default: ;
                            endcase
                        end
                        if (bus.ex_mret) begin
                            m_int_re = 1'b1;
                            m_mie    = o_mpie;
                            m_mpie   = 1'b1;
                        end else if (bus.ex_wfi && !wake) begin
                            m_sleep  = 1'b1;
                            m_wfi_pc = bus.ex_pc;
                        end
                    end
                end
            end else if (wake) begin
                m_sleep = 1'b0;
                if (m_mie) begin
                    m_int  = 1'b1;
                    m_mepc = (m_wfi_pc + 32'd4) & 32'hFFFF_FFFC;
                    m_mpie = 1'b1;
                    m_mie  = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (model_valid) begin
            check("cmp_interrupt", 32'(bus.interrupt), 32'(m_int));
            check("cmp_interrupt_re", 32'(bus.interrupt_re), 32'(m_int_re));
            check("cmp_is_wfi", 32'(bus.is_wfi), 32'(m_sleep));
            check("cmp_mtvec", bus.mtvec, m_mtvec);
            check("cmp_mepc", bus.mepc, m_mepc);
            check("cmp_csr_rdata", bus.csr_rdata, model_read(bus.csr_addr));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [11:0] addr, input logic [31:0] data);
        bus.csr_we    = 1'b1;
        bus.csr_addr  = addr;
        bus.csr_wdata = data;
        cyc();
        bus.csr_we = 1'b0;
    endtask

    task automatic rd(input string name, input logic [11:0] addr, input logic [31:0] exp);
        bus.csr_addr = addr;
        #1;
        check(name, bus.csr_rdata, exp);
    endtask

    task automatic mret();
        bus.ex_mret = 1'b1;
        cyc();
        bus.ex_mret = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        bus.ext_irq   = 1'b0;
        bus.timer_irq = 1'b0;
        bus.bus_stall = 1'b0;
        bus.ex_wfi    = 1'b0;
        bus.ex_mret   = 1'b0;
        bus.ex_pc     = 32'h0;
        bus.csr_we    = 1'b0;
        bus.csr_addr  = 12'h0;
        bus.csr_wdata = 32'h0;
        repeat (2) cyc();
        rst = 1'b0;

        // Reset state
        rd("rst_mtvec", 12'h305, 32'h0001_0000);
        rd("rst_mstatus", 12'h300, 32'h0000_1800);
        rd("rst_mie", 12'h304, 32'h0);
        check("rst_interrupt", 32'(bus.interrupt), 32'h0);
        check("rst_is_wfi", 32'(bus.is_wfi), 32'h0);
        check("rst_mepc", bus.mepc, 32'h0);

        // CSR map masking
        wr(12'h7C0, 32'hFFFF_FFFF);
        rd("unmapped_read", 12'h7C0, 32'h0);
        wr(12'h305, 32'h0002_0003);
        check("mtvec_out_masked", bus.mtvec, 32'h0002_0000);
        wr(12'h300, 32'hFFFF_FFFF);
        rd("mstatus_all_ones", 12'h300, 32'h0000_1888);
        wr(12'h300, 32'h8);
        rd("mstatus_mie_only", 12'h300, 32'h0000_1808);
        wr(12'h304, 32'hFFFF_FFFF);
        rd("mie_all_ones", 12'h304, 32'h0000_0880);
        wr(12'h304, 32'h800);
        bus.timer_irq = 1'b1;
        rd("mip_timer", 12'h344, 32'h80);
        bus.timer_irq = 1'b0;

        // External interrupt entry
        bus.ex_pc   = 32'h120;
        bus.ext_irq = 1'b1;
        rd("mip_ext", 12'h344, 32'h800);
        cyc();
        check("t2_interrupt", 32'(bus.interrupt), 32'h1);
        check("t2_mepc", bus.mepc, 32'h120);
        rd("t2_mstatus", 12'h300, 32'h0000_1880);
        cyc();
        check("t2_pulse_end", 32'(bus.interrupt), 32'h0);

        // MRET with the interrupt still pending: re-entry one cycle later
        mret();
        check("t3_interrupt_re", 32'(bus.interrupt_re), 32'h1);
        check("t3_no_b2b_int", 32'(bus.interrupt), 32'h0);
        rd("t3_mstatus", 12'h300, 32'h0000_1888);
        check("t3_mepc", bus.mepc, 32'h120);
        bus.ex_pc = 32'h140;
        cyc();
        check("t3_re_end", 32'(bus.interrupt_re), 32'h0);
        check("t3_reentry", 32'(bus.interrupt), 32'h1);
        check("t3_reentry_mepc", bus.mepc, 32'h140);
        bus.ext_irq = 1'b0;
        cyc();
        mret();
        cyc();

        // WFI sleep, timer wake with MIE=1 (bus_stall ignored while asleep)
        wr(12'h304, 32'h80);
        bus.ex_wfi = 1'b1;
        bus.ex_pc  = 32'h200;
        cyc();
        bus.ex_wfi    = 1'b0;
        bus.bus_stall = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check("t4_sleep_held", 32'(bus.is_wfi), 32'h1);
            cyc();
        end
        bus.timer_irq = 1'b1;
        cyc();
        check("t4_interrupt", 32'(bus.interrupt), 32'h1);
        check("t4_mepc", bus.mepc, 32'h204);
        check("t4_awake", 32'(bus.is_wfi), 32'h0);
        bus.timer_irq = 1'b0;
        bus.bus_stall = 1'b0;
        cyc();
        mret();
        cyc();

        // WFI wake with MIE=0: resume without trap; WFI with wake pending is a NOP
        wr(12'h300, 32'h0);
        bus.ex_wfi = 1'b1;
        bus.ex_pc  = 32'h300;
        cyc();
        bus.ex_wfi = 1'b0;
        check("t5_sleep", 32'(bus.is_wfi), 32'h1);
        repeat (3) cyc();
        bus.timer_irq = 1'b1;
        cyc();
        check("t5_awake", 32'(bus.is_wfi), 32'h0);
        check("t5_no_interrupt", 32'(bus.interrupt), 32'h0);
        check("t5_mepc_kept", bus.mepc, 32'h204);
        bus.ex_wfi = 1'b1;
        bus.ex_pc  = 32'h304;
        cyc();
        bus.ex_wfi = 1'b0;
        check("t5_wfi_nop", 32'(bus.is_wfi), 32'h0);
        bus.timer_irq = 1'b0;
        cyc();

        // Stall holds off trap and CSR write; take drops a same-cycle write
        wr(12'h300, 32'h8);
        wr(12'h304, 32'h800);
        bus.bus_stall = 1'b1;
        bus.ext_irq   = 1'b1;
        bus.ex_pc     = 32'h400;
        bus.csr_we    = 1'b1;
        bus.csr_addr  = 12'h305;
        bus.csr_wdata = 32'h5550;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("t6_stall_no_int", 32'(bus.interrupt), 32'h0);
        end
        check("t6_stall_no_write", bus.mtvec, 32'h0002_0000);
        bus.csr_we    = 1'b0;
        bus.bus_stall = 1'b0;
        cyc();
        check("t6_int_after_stall", 32'(bus.interrupt), 32'h1);
        check("t6_mepc", bus.mepc, 32'h400);
        bus.ext_irq = 1'b0;
        mret();
        cyc();
        bus.ext_irq   = 1'b1;
        bus.ex_pc     = 32'h480;
        bus.csr_we    = 1'b1;
        bus.csr_addr  = 12'h305;
        bus.csr_wdata = 32'h7770;
        cyc();
        bus.csr_we = 1'b0;
        check("t6_take_int", 32'(bus.interrupt), 32'h1);
        check("t6_write_dropped", bus.mtvec, 32'h0002_0000);
        check("t6_take_mepc", bus.mepc, 32'h480);
        bus.ext_irq = 1'b0;
        mret();
        cyc();

        // mepc wraps when the WFI sits at the top of the address space
        bus.ex_wfi = 1'b1;
        bus.ex_pc  = 32'hFFFF_FFFC;
        cyc();
        bus.ex_wfi = 1'b0;
        check("t7_sleep", 32'(bus.is_wfi), 32'h1);
        bus.ext_irq = 1'b1;
        cyc();
        check("t7_interrupt", 32'(bus.interrupt), 32'h1);
        check("t7_mepc_wrap", bus.mepc, 32'h0);
        bus.ext_irq = 1'b0;
        cyc();

        // Reset while asleep
        mret();
        bus.ex_wfi = 1'b1;
        bus.ex_pc  = 32'h500;
        cyc();
        bus.ex_wfi = 1'b0;
        check("t8_sleep", 32'(bus.is_wfi), 32'h1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("t8_rst_is_wfi", 32'(bus.is_wfi), 32'h0);
        check("t8_rst_mtvec", bus.mtvec, 32'h0001_0000);
        check("t8_rst_mepc", bus.mepc, 32'h0);
        rd("t8_rst_mstatus", 12'h300, 32'h0000_1800);
        repeat (2) cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
